hci_core_rr_arbiter_ordered: RTL
================================

Name: hci_core_rr_arbiter_ordered

Overview:
- Shares one HCI core target port (e.g. the upstream side of a memory-map demux) among NB_IN initiators.
- Arbitration is round-robin; each granted transaction's initiator index is logged in an ID FIFO.
- In-order responses are routed back to the originating initiator.
- Sits between cluster-side masters (cores, DMA, accelerators) and the region demux.

Parameters:
- NB_IN, 4, number of initiator ports (≥2)
- AW, 32, address width
- DW, 32, data width
- UW, 1, user width
- MAX_OUTST, 4, max outstanding granted-but-unanswered transactions (power of 2, ≥1)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- clear_i  in  1  synchronous soft clear, same effect as rst_i
- in_req_i  in  NB_IN  per-initiator request
- in_gnt_o  out  NB_IN  per-initiator grant
- in_add_i  in  NB_IN×AW  address
- in_wen_i  in  NB_IN  1 = read, 0 = write
- in_data_i  in  NB_IN×DW  write data
- in_be_i  in  NB_IN×DW/8  byte enables
- in_user_i  in  NB_IN×UW  request user bits
- in_r_valid_o  out  NB_IN  response valid
- in_r_ready_i  in  NB_IN  response ready
- in_r_data_o  out  DW  response data, shared by all initiators, qualified by in_r_valid_o
- in_r_user_o  out  UW  response user bits, shared, qualified by in_r_valid_o
- tgt_req_o  out  1  target request
- tgt_gnt_i  in  1  target grant
- tgt_add_o / tgt_wen_o / tgt_data_o / tgt_be_o / tgt_user_o  out  AW / 1 / DW / DW/8 / UW  forwarded request fields
- tgt_r_valid_i  in  1  target response valid
- tgt_r_ready_o  out  1  target response ready
- tgt_r_data_i / tgt_r_user_i  in  DW / UW  target response
- err_spurious_o  out  1  one-cycle pulse on a response arriving with no outstanding entry

Behaviour:
- Clock and reset: clk_i single clock; rst_i synchronous, active-high.
- State: rr_q (clog2 NB_IN bits), ID FIFO of depth MAX_OUTST holding winner indices, cnt_q (0..MAX_OUTST).
- Reset/clear: rr_q=0, FIFO empty, cnt_q=0, err_spurious_o=0.
- Request path (combinational, 0-cycle latency):
  - full = (cnt_q==MAX_OUTST).
  - Winner w = first index with in_req_i set, scanning rr_q, rr_q+1, … modulo NB_IN.
  - tgt_req_o = |in_req_i & ~full. tgt_* fields = in_*_i[w]; they are '0 when no request.
  - in_gnt_o[w] = tgt_gnt_i & ~full; all other in_gnt_o bits = 0.
- Handshake (accept = tgt_req_o & tgt_gnt_i):
  - Push w into the FIFO.
  - rr_q <= (w+1) mod NB_IN. rr_q is unchanged without accept.
  - The winner may change between cycles while tgt_gnt_i is low; there is no request locking.
- Every accepted transaction (read or write) expects exactly one response, in order.
- Response path (combinational):
  - h = FIFO head.
  - If cnt_q>0: in_r_valid_o[h] = tgt_r_valid_i, other bits 0; tgt_r_ready_o = in_r_ready_i[h].
  - in_r_data_o and in_r_user_o always equal tgt_r_data_i / tgt_r_user_i.
  - Pop on tgt_r_valid_i & tgt_r_ready_o.
- Empty FIFO with tgt_r_valid_i=1:
  - tgt_r_ready_o=1 (drain); all in_r_valid_o=0.
  - err_spurious_o=1 in the next cycle (registered pulse).
- Simultaneous push and pop: cnt_q unchanged, FIFO pointers both advance.
- When full, no push even if a pop occurs in the same cycle (tgt_req_o already 0).
- Pointer wrap: read and write pointers wrap modulo MAX_OUTST.
- rst_i/clear_i mid-operation: outstanding IDs are discarded; later responses are treated as spurious.

Test Plan:
- NB_IN=4, all in_req_i=1111, tgt_gnt_i=1, 8 cycles, responses with latency 1 -> grants in order 0,1,2,3,0,1,2,3; each r_data returns to the matching initiator.
- in_req_i=0100 only, rr_q=0 -> in_gnt_o=0100 the same cycle; rr_q becomes 3 after accept.
- tgt_r_valid_i held 0, 5 accepts attempted with MAX_OUTST=4 -> 4 grants, then tgt_req_o=0 and cnt_q=4. One response pop -> request accepted the next cycle.
- Full FIFO with pop and pending request in the same cycle -> no grant that cycle; grant the following cycle.
- Response to initiator 2 with in_r_ready_i[2]=0 for 3 cycles -> tgt_r_ready_o=0 and no pop; pop on the cycle ready rises.
- rst_i asserted with 2 outstanding, then tgt_r_valid_i=1 -> tgt_r_ready_o=1, in_r_valid_o=0000, err_spurious_o pulses 1 cycle.

Source files
------------

// File: rtl/hci_core_rr_arbiter_ordered.sv
// rtl/hci_core_rr_arbiter_ordered.sv - round-robin HCI arbiter with in-order response routing
// Winner indices are queued in an ID FIFO so responses return to the initiator that issued them.
module hci_core_rr_arbiter_ordered #(
  parameter int NB_IN     = 4,
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int UW        = 1,
  parameter int MAX_OUTST = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           clear_i,
  input  logic [NB_IN-1:0]               in_req_i,
  output logic [NB_IN-1:0]               in_gnt_o,
  input  logic [NB_IN-1:0][AW-1:0]       in_add_i,
  input  logic [NB_IN-1:0]               in_wen_i,
  input  logic [NB_IN-1:0][DW-1:0]       in_data_i,
  input  logic [NB_IN-1:0][DW/8-1:0]     in_be_i,
  input  logic [NB_IN-1:0][UW-1:0]       in_user_i,
  output logic [NB_IN-1:0]               in_r_valid_o,
  input  logic [NB_IN-1:0]               in_r_ready_i,
  output logic [DW-1:0]                  in_r_data_o,
  output logic [UW-1:0]                  in_r_user_o,
  output logic                           tgt_req_o,
  input  logic                           tgt_gnt_i,
  output logic [AW-1:0]                  tgt_add_o,
  output logic                           tgt_wen_o,
  output logic [DW-1:0]                  tgt_data_o,
  output logic [DW/8-1:0]                tgt_be_o,
  output logic [UW-1:0]                  tgt_user_o,
  input  logic                           tgt_r_valid_i,
  output logic                           tgt_r_ready_o,
  input  logic [DW-1:0]                  tgt_r_data_i,
  input  logic [UW-1:0]                  tgt_r_user_i,
  output logic                           err_spurious_o
);

  localparam int IDW = (NB_IN > 1) ? $clog2(NB_IN) : 1;
  localparam int PW  = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int CW  = $clog2(MAX_OUTST + 1);

  logic [IDW-1:0] rr_q, rr_d, win, head;
  logic [IDW-1:0] fifo_q [MAX_OUTST];
  logic [PW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           err_q, err_d;
  logic           any_req, found, full, empty, accept, pop;
  int             idx;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTST - 1)) ? '0 : p + 1'b1;
  endfunction

  // First requester at or after rr_q, wrapping around.
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NB_IN; k++) begin
      idx = (int'(rr_q) + k) % NB_IN;
      if (!found && in_req_i[idx]) begin
        found = 1'b1;
        win   = IDW'(idx);
      end
    end
  end

  assign any_req   = |in_req_i;
  assign full      = (cnt_q == CW'(MAX_OUTST));
  assign empty     = (cnt_q == '0);
  assign tgt_req_o = any_req & ~full;
  assign accept    = tgt_req_o & tgt_gnt_i;
  assign head      = fifo_q[rptr_q];

  always_comb begin
    in_gnt_o   = '0;
    tgt_add_o  = '0;
    tgt_wen_o  = 1'b0;
    tgt_data_o = '0;
    tgt_be_o   = '0;
    tgt_user_o = '0;
    if (any_req) begin
      in_gnt_o[win] = tgt_gnt_i & ~full;
      tgt_add_o     = in_add_i[win];
      tgt_wen_o     = in_wen_i[win];
      tgt_data_o    = in_data_i[win];
      tgt_be_o      = in_be_i[win];
      tgt_user_o    = in_user_i[win];
    end
  end

  // With nothing outstanding, stray responses are drained rather than stalling the target.
  always_comb begin
    in_r_valid_o  = '0;
    tgt_r_ready_o = 1'b1;
    if (!empty) begin
      in_r_valid_o[head] = tgt_r_valid_i;
      tgt_r_ready_o      = in_r_ready_i[head];
    end
  end

  assign in_r_data_o    = tgt_r_data_i;
  assign in_r_user_o    = tgt_r_user_i;
  assign pop            = tgt_r_valid_i & tgt_r_ready_o & ~empty;
  assign err_d          = tgt_r_valid_i & empty;
  assign err_spurious_o = err_q;

  always_comb begin
    rr_d   = rr_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q + CW'(accept) - CW'(pop);
    if (accept) begin
      rr_d   = (win == IDW'(NB_IN - 1)) ? '0 : win + 1'b1;
      wptr_d = ptr_inc(wptr_q);
    end
    if (pop) rptr_d = ptr_inc(rptr_q);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      rr_q   <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      rr_q   <= rr_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept && !(rst_i || clear_i)) fifo_q[wptr_q] <= win;
  end

endmodule
